trace_drain: RTL and testbench

- Consumer-side reader for the trace buffer.
- Issues data_request pulses, captures each trace_output element the buffer returns, and serialises it LSB-first into fixed-width beats on a valid/ready stream, ready for the host link (UART/DMA bridge).
- Sits between trace_buffer and the off-chip export path; it is the reader half of the buffer's ready_signal/data_request protocol.

---
 rtl/ryuki_datatypes.sv | 26 ++
 rtl/trace_drain_serialiser.sv | 87 ++++++++
 rtl/trace_drain.sv | 118 +++++++++++
 tb/tb_trace_drain.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ryuki_datatypes.sv
// Shared trace datatypes: the buffer element format plus the drain-side state
// encoding and beat-count helper.
package ryuki_datatypes;

  typedef struct packed {
    logic [7:0]  event_id;
    logic [15:0] payload;
    logic [31:0] time_end;
    logic [31:0] time_start;
  } trace_output;

  localparam int unsigned TRACE_W = $bits(trace_output);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    GAP  = 3'd3,
    SEND = 3'd4
  } drain_state_t;

  function automatic int unsigned calc_nbeats(input int unsigned tw, input int unsigned ow);
    return (tw + ow - 32'd1) / ow;
  endfunction

endpackage

// File: rtl/trace_drain_serialiser.sv
// Holds one captured trace element and walks it out LSB-first as fixed-width
// beats on a valid/ready stream; pulses done on the final beat's transfer.
module trace_serialiser
  import ryuki_datatypes::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  trace_output      elem,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             done
);

  localparam int NBEATS = int'(calc_nbeats(TRACE_W, OUT_W));
  localparam int PAD_W  = NBEATS * OUT_W;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic [PAD_W-1:0] elem_q, elem_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [PAD_W-1:0] load_pad_s;

  // Zero-extend the element so the last beat carries zero padding.
  always_comb begin
    load_pad_s = '0;
    load_pad_s[TRACE_W-1:0] = elem;
  end

  // Beat sequencing: load on capture, advance on each accepted beat.
  always_comb begin
    elem_d  = elem_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done    = valid_q & out_ready & last_q;
    if (load) begin
      elem_d  = load_pad_s;
      idx_d   = '0;
      data_d  = load_pad_s[OUT_W-1:0];
      valid_d = 1'b1;
      last_d  = (NBEATS == 1);
    end else if (valid_q && out_ready) begin
      if (last_q) begin
        idx_d   = '0;
        data_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
        data_d = elem_q[int'(idx_d) * OUT_W +: OUT_W];
        last_d = (idx_d == IDX_W'(NBEATS - 1));
      end
    end else begin
      data_d = data_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      elem_q  <= elem_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule

// File: rtl/trace_drain.sv
// Reader half of the trace buffer handshake: requests elements, times out
// silent requests, and hands captured elements to the beat serialiser.
module trace_drain
  import ryuki_datatypes::*;
#(
  parameter int OUT_W     = 32,
  parameter int TIMEOUT   = 16,
  parameter int RETRY_GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             data_request,
  input  trace_output      trace_element_out,
  input  logic             data_present,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [15:0]      drained_count,
  output logic [7:0]       timeout_count
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int GCW = $clog2(RETRY_GAP + 1);

  drain_state_t   state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]    drained_q, drained_d;
  logic [7:0]     timeout_q, timeout_d;
  logic           data_request_q, data_request_d;
  logic           load_s;
  logic           done_s;

  // Next-state and counter logic; data_present only matters in WAIT.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    drained_d  = drained_q;
    timeout_d  = timeout_q;
    load_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = REQ;
        else        state_d = IDLE;
      end
      REQ: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (data_present) begin
          load_s  = 1'b1;
          state_d = SEND;
        end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          if (timeout_q != 8'hFF) timeout_d = timeout_q + 8'd1;
          else                    timeout_d = timeout_q;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GCW'(RETRY_GAP - 1)) state_d = IDLE;
        else                                   gap_cnt_d = gap_cnt_q + GCW'(1);
      end
      SEND: begin
        if (done_s) begin
          drained_d = drained_q + 16'd1;
          state_d   = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
    data_request_d = (state_d == REQ);
  end

  // FSM, counters and the registered request pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      wait_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      drained_q      <= 16'd0;
      timeout_q      <= 8'd0;
      data_request_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      drained_q      <= drained_d;
      timeout_q      <= timeout_d;
      data_request_q <= data_request_d;
    end
  end

  trace_serialiser #(.OUT_W(OUT_W)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .elem      (trace_element_out),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .done      (done_s)
  );

  assign data_request  = data_request_q;
  assign drained_count = drained_q;
  assign timeout_count = timeout_q;

endmodule

// File: tb/tb_trace_drain.sv
// Directed bench for trace_drain with OUT_W=32: 88-bit elements give three
// beats, the last carrying 8 bits of zero padding.
module tb_trace_drain;
  import ryuki_datatypes::*;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        data_request;
  trace_output elem;
  logic        data_present;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] drained_count;
  logic [7:0]  timeout_count;

  int checks;
  int errors;

  trace_drain #(.OUT_W(32), .TIMEOUT(16), .RETRY_GAP(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .data_request      (data_request),
    .trace_element_out (elem),
    .data_present      (data_present),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .drained_count     (drained_count),
    .timeout_count     (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic trace_output mk_elem(input logic [31:0] ts);
    trace_output e;
    e.event_id   = 8'hA5;
    e.payload    = 16'h1234;
    e.time_end   = ts + 32'd10;
    e.time_start = ts;
    return e;
  endfunction

  task automatic wait_request(input string tag);
    int n;
    n = 0;
    while (data_request !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk_val(tag, {31'd0, data_request}, 32'd1);
  endtask

  task automatic answer(input int delay, input trace_output e);
    repeat (delay) @(negedge clk);
    data_present = 1'b1;
    elem         = e;
    @(negedge clk);
    data_present = 1'b0;
    elem         = '0;
    chk_val("first_beat_latency", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic collect(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                         input bit toggle, input bit inject);
    int k;
    int cyc;
    logic [31:0] exp_b;
    k   = 0;
    cyc = 0;
    while (k < 3 && cyc < 50) begin
      out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (inject && cyc == 1) begin
        data_present = 1'b1;
        elem         = mk_elem(32'd999);
      end else begin
        data_present = 1'b0;
        elem         = '0;
      end
      case (k)
        0:       exp_b = e0;
        1:       exp_b = e1;
        default: exp_b = e2;
      endcase
      chk_val("beat_valid", {31'd0, out_valid}, 32'd1);
      chk_val($sformatf("beat%0d_data", k), out_data, exp_b);
      chk_val($sformatf("beat%0d_last", k), {31'd0, out_last}, (k == 2) ? 32'd1 : 32'd0);
      if (out_ready) k++;
      @(negedge clk);
      cyc++;
    end
    data_present = 1'b0;
    elem         = '0;
    chk_val("beats_done_in_budget", k, 32'd3);
    chk_val("valid_drops_after_last", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int  ts_tab [4];
    bit  early;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    enable       = 1'b0;
    data_present = 1'b0;
    elem         = '0;
    out_ready    = 1'b0;
    ts_tab       = '{100, 200, 300, 400};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_val("rst_req",     {31'd0, data_request}, 32'd0);
    chk_val("rst_valid",   {31'd0, out_valid},    32'd0);
    chk_val("rst_last",    {31'd0, out_last},     32'd0);
    chk_val("rst_data",    out_data,              32'd0);
    chk_val("rst_drained", {16'd0, drained_count}, 32'd0);
    chk_val("rst_timeout", {24'd0, timeout_count}, 32'd0);

    // 1: basic drain, buffer answers two cycles after the request
    enable = 1'b1;
    wait_request("t1_req");
    enable = 1'b0;
    @(negedge clk);
    chk_val("t1_req_one_cycle", {31'd0, data_request}, 32'd0);
    answer(1, mk_elem(32'd100));
    collect(32'h0000_0064, 32'h0000_006E, 32'h00A5_1234, 1'b0, 1'b0);
    chk_val("t1_drained", {16'd0, drained_count}, 32'd1);

    // 2: downstream stalls every other cycle
    enable = 1'b1;
    wait_request("t2_req");
    enable = 1'b0;
    answer(2, mk_elem(32'd100));
    collect(32'h0000_0064, 32'h0000_006E, 32'h00A5_1234, 1'b1, 1'b0);
    chk_val("t2_drained", {16'd0, drained_count}, 32'd2);

    // 3: silent buffer times out, retry timing, then data on the last WAIT cycle
    enable = 1'b1;
    wait_request("t3_req");
    early = 1'b0;
    for (int t = 1; t <= 22; t++) begin
      @(negedge clk);
      if (t == 16) chk_val("t3_timeout_pre",  {24'd0, timeout_count}, 32'd0);
      if (t == 17) chk_val("t3_timeout_post", {24'd0, timeout_count}, 32'd1);
      if (t < 22 && data_request === 1'b1) early = 1'b1;
    end
    chk_val("t3_retry_req", {31'd0, data_request}, 32'd1);
    chk_val("t3_no_early_req", {31'd0, early}, 32'd0);
    enable = 1'b0;
    answer(16, mk_elem(32'd300));
    collect(32'd300, 32'd310, 32'h00A5_1234, 1'b0, 1'b0);
    chk_val("t3_timeout_held", {24'd0, timeout_count}, 32'd1);
    chk_val("t3_drained", {16'd0, drained_count}, 32'd3);

    // 4: stray data_present in IDLE and in SEND is ignored
    data_present = 1'b1;
    elem         = mk_elem(32'd777);
    @(negedge clk);
    data_present = 1'b0;
    elem         = '0;
    @(negedge clk);
    chk_val("t4_idle_valid", {31'd0, out_valid}, 32'd0);
    chk_val("t4_idle_req",   {31'd0, data_request}, 32'd0);
    enable = 1'b1;
    wait_request("t4_req");
    enable = 1'b0;
    answer(1, mk_elem(32'd400));
    collect(32'd400, 32'd410, 32'h00A5_1234, 1'b1, 1'b1);
    chk_val("t4_drained", {16'd0, drained_count}, 32'd4);

    // 5: four back-to-back elements with enable held
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_request("t5_req");
      if (i == 3) enable = 1'b0;
      answer(1, mk_elem(ts_tab[i]));
      collect(ts_tab[i], ts_tab[i] + 32'd10, 32'h00A5_1234, 1'b0, 1'b0);
    end
    chk_val("t5_drained", {16'd0, drained_count}, 32'd8);

    // 6: asynchronous reset while beat 1 is pending
    enable = 1'b1;
    wait_request("t6_req");
    answer(1, mk_elem(32'd500));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_val("t6_beat1", out_data, 32'd510);
    #2;
    rst = 1'b1;
    #1;
    chk_val("t6_rst_valid",   {31'd0, out_valid},     32'd0);
    chk_val("t6_rst_data",    out_data,               32'd0);
    chk_val("t6_rst_last",    {31'd0, out_last},      32'd0);
    chk_val("t6_rst_req",     {31'd0, data_request},  32'd0);
    chk_val("t6_rst_drained", {16'd0, drained_count}, 32'd0);
    chk_val("t6_rst_timeout", {24'd0, timeout_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_val("t6_restart_req", {31'd0, data_request}, 32'd1);
    enable = 1'b0;
    answer(1, mk_elem(32'd600));
    collect(32'd600, 32'd610, 32'h00A5_1234, 1'b0, 1'b0);
    chk_val("t6_drained", {16'd0, drained_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
